debug_net_injector: RTL and testbench
=====================================

# debug_net_injector

Downstream consumer of the debug CPU's 32-bit network-injection output port. Converts the level-held PIO word into discrete network flits using a toggle-handshake convention: bit 31 flips once per new word. Each new word is queued in a small FIFO and presented to the neuromorphic network injection port over valid/ready. A status word is returned for a companion input PIO so firmware can poll acknowledge, occupancy and drops.

## Interface
- FIFO_DEPTH, 8, flit queue depth; power of two, >= 2
- DEST_W, 7, destination field width (pio_word[30:24])
- DATA_W, 24, payload field width (pio_word[23:0])

- clk  in  1  system clock
- reset_n  in  1  reset: asynchronous, active-low
- pio_word  in  32  PIO output word; [31] send toggle, [30:24] dest, [23:0] data
- ovf_clr  in  1  one-cycle pulse; clears overflow flag and drop counter
- net_valid  out  1  flit available to network
- net_ready  in  1  network accepts flit this cycle
- net_dest  out  DEST_W  flit destination
- net_data  out  DATA_W  flit payload
- status  out  32  [31] ack toggle, [30] overflow, [29] full, [28] empty, [27:16] 0, [15:8] drop count, [7:0] level

## Operation
- tog_q: registered copy of last seen pio_word[31]; reset 0, matching the PIO's reset value, so no spurious event after reset.
- Event: pio_word[31] != tog_q, evaluated combinationally each cycle. On event, tog_q <= pio_word[31] unconditionally.
- Push on event when FIFO not full, or when full and a pop occurs the same cycle. The entry is {pio_word[30:24], pio_word[23:0]}, captured on the event cycle.
- Drop on event when full and no same-cycle pop. Set overflow (sticky); increment drop count, saturating at 255. tog_q still updates, so ack reflects "seen", not "queued".
- Pop when net_valid && net_ready. net_valid = ~empty. net_dest/net_data = head entry (show-ahead), held stable while net_valid && !net_ready.
- Level: 0..FIFO_DEPTH, width $clog2(FIFO_DEPTH)+1, zero-extended into status[7:0]. Push and pop in the same cycle leave level unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH.
- ovf_clr clears overflow and drop count. If ovf_clr and a drop occur in the same cycle, the drop wins: overflow=1, count=1.
- Reset values: tog_q=0, pointers=0, level=0, overflow=0, drop count=0, net_valid=0, net_dest/net_data=0, status=0x1000_0000 (empty=1).

## Timing
- PIO write lands on edge N. Event is visible in cycle N..N+1. Push occurs on edge N+1, and net_valid is high after edge N+1: one-cycle injection latency.
- status is registered from post-edge state; ack reflects tog_q in the cycle after the event.
- Back-to-back PIO writes on consecutive cycles are each captured, because every write must flip bit 31.
- A write that does not flip bit 31 is ignored.
- Asynchronous reset mid-transfer discards all queued flits. net_valid drops immediately, with no partial handshake completed.

## Structure
- Package debug_net_pkg holds:
  - field constants: TOG_BIT=31, DEST_HI/LO=30/24, DATA_HI/LO=23/0
  - status bit positions
  - flit struct typedef {dest, data}
- Sub-module debug_net_fifo: synchronous show-ahead FIFO. Ports push/pop/full/empty/level, parameterised by depth and width. The top level holds only toggle detection, drop/overflow logic and status packing.

## Test plan
- Reset, then hold pio_word=0 -> net_valid=0, status=0x1000_0000, no push.
- Write 0x8123_4567 -> after 1 edge net_valid=1, net_dest=0x01, net_data=0x234567. With net_ready=1 -> pops, status empty=1, ack=1.
- net_ready=0; nine toggling writes (depth 8) -> level=8, full=1, overflow=1, drop count=1. Flits drain in write order when ready rises.
- Full FIFO with net_ready=1 and a new event in the same cycle -> push accepted, level stays 8, no drop.
- Rewrite with bit 31 unchanged -> no push. Then ovf_clr pulse -> overflow=0, drop count=0.
- Assert reset_n low with 3 queued flits -> net_valid=0 immediately. After release, level=0 and no flit emitted.

Source files
------------

// File: rtl/debug_net_pkg.sv
// rtl/debug_net_pkg.sv - shared field positions, status layout and flit type for the debug network injector
//
// Purpose: single home for the PIO word field map, the status word bit map
// and the flit record, so the injector, its FIFO and firmware-facing
// documentation all agree on one layout.
package debug_net_pkg;

  // PIO output word fields
  localparam int TOG_BIT = 31;
  localparam int DEST_HI = 30;
  localparam int DEST_LO = 24;
  localparam int DATA_HI = 23;
  localparam int DATA_LO = 0;

  // Status word fields
  localparam int ST_ACK     = 31;
  localparam int ST_OVF     = 30;
  localparam int ST_FULL    = 29;
  localparam int ST_EMPTY   = 28;
  localparam int ST_DROP_HI = 15;
  localparam int ST_DROP_LO = 8;
  localparam int ST_LVL_HI  = 7;
  localparam int ST_LVL_LO  = 0;

  localparam int FLIT_DEST_W = DEST_HI - DEST_LO + 1;
  localparam int FLIT_DATA_W = DATA_HI - DATA_LO + 1;

  typedef struct packed {
    logic [FLIT_DEST_W-1:0] dest;
    logic [FLIT_DATA_W-1:0] data;
  } flit_t;

endpackage

// File: rtl/debug_net_fifo.sv
// rtl/debug_net_fifo.sv - synchronous show-ahead flit FIFO
//
// Purpose: small circular queue whose head entry is always visible on
// rd_data. A push while full is accepted only when a pop happens in the same
// cycle, so the caller may offer a push whenever it likes.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   push, wr_data     enqueue request and entry
//   pop               dequeue request (ignored while empty)
//   rd_data           head entry (show-ahead)
//   full, empty       occupancy flags
//   level             number of stored entries, 0..DEPTH
module debug_net_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 31,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  // When full, the slot being written is the one being popped this cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Cleared so the head reads as zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop)      count <= count + LVL_ONE;
      else if (!do_push && do_pop) count <= count - LVL_ONE;
    end
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == LVL_MAX);
  assign empty   = (count == '0);
  assign level   = count;

endmodule

// File: rtl/debug_net_injector.sv
// rtl/debug_net_injector.sv - turns toggle-handshake PIO writes into queued network flits
//
// Purpose: watches the debug CPU's level-held PIO word; every flip of bit 31
// is one new flit {dest, data}. Flits are queued and offered to the network
// over valid/ready. Events arriving while the queue is full (and not draining
// that cycle) are dropped and counted. A status word lets firmware poll ack,
// occupancy and drops.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   pio_word              [31] send toggle, [30:24] dest, [23:0] data
//   ovf_clr               pulse: clear overflow flag and drop count
//   net_valid/net_ready   flit handshake towards the network
//   net_dest, net_data    head flit fields
//   status                [31] ack, [30] overflow, [29] full, [28] empty,
//                         [15:8] drop count, [7:0] level
module debug_net_injector
  import debug_net_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DEST_W     = 7,
  parameter int DATA_W     = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       pio_word,
  input  logic              ovf_clr,
  output logic              net_valid,
  input  logic              net_ready,
  output logic [DEST_W-1:0] net_dest,
  output logic [DATA_W-1:0] net_data,
  output logic [31:0]       status
);

  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int FLIT_W = DEST_W + DATA_W;

  logic              tog_q;
  logic              overflow;
  logic [7:0]        drop_cnt;
  logic              tog_event;
  logic              pop;
  logic              push;
  logic              drop;
  logic              full;
  logic              empty;
  logic [LVL_W-1:0]  level;
  logic [FLIT_W-1:0] head;

  assign tog_event = (pio_word[TOG_BIT] != tog_q);
  assign pop       = net_valid && net_ready;
  assign push      = tog_event && (!full || pop);
  assign drop      = tog_event && full && !pop;

  debug_net_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FLIT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wr_data ({pio_word[DEST_LO +: DEST_W], pio_word[DATA_LO +: DATA_W]}),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // tog_q tracks every event, queued or dropped: ack means "seen".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tog_q    <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (tog_event) tog_q <= pio_word[TOG_BIT];
      // A drop in the same cycle as a clear wins and restarts the count at 1.
      if (drop) begin
        overflow <= 1'b1;
        if (ovf_clr)                 drop_cnt <= 8'd1;
        else if (drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end
    end
  end

  assign net_valid          = !empty;
  assign {net_dest, net_data} = head;

  // Packed purely from registered state, so it reflects post-edge values.
  always_comb begin
    status                        = '0;
    status[ST_ACK]                = tog_q;
    status[ST_OVF]                = overflow;
    status[ST_FULL]               = full;
    status[ST_EMPTY]              = empty;
    status[ST_DROP_HI:ST_DROP_LO] = drop_cnt;
    status[ST_LVL_HI:ST_LVL_LO]   = 8'(level);
  end

endmodule

// File: tb/tb_debug_net_injector.sv
// tb/tb_debug_net_injector.sv - scoreboard bench for debug_net_injector
module tb_debug_net_injector;
  import debug_net_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] pio_word = '0;
  logic        ovf_clr = 1'b0;
  logic        net_valid;
  logic        net_ready = 1'b0;
  logic [6:0]  net_dest;
  logic [23:0] net_data;
  logic [31:0] status;

  int n_checks = 0;
  int n_pass   = 0;
  flit_t exp_q[$];

  debug_net_injector #(.FIFO_DEPTH(8), .DEST_W(7), .DATA_W(24)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pio_word  (pio_word),
    .ovf_clr   (ovf_clr),
    .net_valid (net_valid),
    .net_ready (net_ready),
    .net_dest  (net_dest),
    .net_data  (net_data),
    .status    (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a PIO write; queue its flit only when the bench expects it accepted.
  task automatic pio_write(input logic [31:0] w, input bit queued);
    tick();
    pio_word = w;
    if (queued) exp_q.push_back(flit_t'(w[30:0]));
  endtask

  // Every accepted handshake must match the oldest expected flit.
  always @(negedge clk) begin
    if (reset_n && net_valid && net_ready) begin
      check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        flit_t f;
        f = exp_q.pop_front();
        check("flit", {1'b0, net_dest, net_data}, {1'b0, f});
      end
    end
  end

  initial begin
    logic [31:0] w;
    bit tog;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_valid", 32'(net_valid), 32'd0);
    check("reset_status", status, 32'h1000_0000);

    // Single flit, one-cycle latency, then popped
    pio_write(32'h8123_4567, 1'b1);
    @(negedge clk);
    check("latency_valid_low", 32'(net_valid), 32'd0);
    tick();
    net_ready = 1'b1;
    @(negedge clk);
    check("single_valid", 32'(net_valid), 32'd1);
    check("single_dest", 32'(net_dest), 32'h01);
    check("single_data", 32'(net_data), 32'h23_4567);
    tick();
    net_ready = 1'b0;
    @(negedge clk);
    check("single_status", status, 32'h9000_0000);

    // Nine back-to-back writes into a depth-8 queue: last one drops
    tog = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tog = ~tog;
      w = {tog, 7'(k + 2), 24'(k * 24'h111 + 24'h5)};
      pio_write(w, k < 8);
    end
    tick();
    @(negedge clk);
    check("overflow_status", status, 32'h6000_0108);

    // Full queue, pop and push together: accepted, no drop
    tick();
    net_ready = 1'b1;
    pio_word = {1'b1, 7'h40, 24'hAB_CDEF};
    exp_q.push_back(flit_t'(pio_word[30:0]));
    tick();
    net_ready = 1'b0;
    @(negedge clk);
    check("full_swap_status", status, 32'hE000_0108);

    // Rewrite without flipping the toggle: ignored
    pio_write({1'b1, 7'h11, 24'h11_1111}, 1'b0);
    tick();
    @(negedge clk);
    check("no_toggle_status", status, 32'hE000_0108);

    // Clear overflow and drop count
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("ovf_clr_status", status, 32'hA000_0008);

    // Drop coinciding with clear: drop wins, count restarts at 1
    tick();
    ovf_clr = 1'b1;
    pio_word = {1'b0, 7'h22, 24'h22_2222};
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    check("drop_vs_clr_status", status, 32'h6000_0108);

    // Drain in write order
    net_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() != 0; c++) @(posedge clk);
    #1 net_ready = 1'b0;
    check("drain_done", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("drained_status", status, 32'h5000_0100);

    // Reset with three flits queued
    pio_write({1'b1, 7'h31, 24'h00_0031}, 1'b1);
    pio_write({1'b0, 7'h32, 24'h00_0032}, 1'b1);
    pio_write({1'b1, 7'h33, 24'h00_0033}, 1'b1);
    tick();
    @(negedge clk);
    check("three_queued_status", status, 32'hC000_0103);
    #1;
    reset_n  = 1'b0;
    pio_word = '0;
    #1;
    check("reset_valid_async", 32'(net_valid), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    reset_n   = 1'b1;
    net_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("post_reset_valid", 32'(net_valid), 32'd0);
    check("post_reset_status", status, 32'h1000_0000);
    net_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
